// File: rtl/dvs_aer_transmitter_if.sv
// Word-serial AER bus between a DVS transmitter (master) and receiver (slave).
// The master drives the address word, its X/Y select and req; the slave answers with ack.
interface dvs_aer_transmitter_if;
   logic [9:0] aer;
   logic       xsel;
   logic       req;
   logic       ack;

   modport master (output aer, output xsel, output req, input ack);
   modport slave  (input aer, input xsel, input req, output ack);
endinterface

// File: rtl/dvs_aer_transmitter.sv
// DVS word-serial AER transmitter: parallel events in, Y/X address words out over a four-phase req/ack handshake.
// Optional handshake watchdog: define DVS_AER_TX_TIMEOUT_EN.
module dvs_aer_transmitter #(
   parameter int DVS_X_ADDR_BITS = 7,
   parameter int DVS_Y_ADDR_BITS = 7,
   parameter int SETUP_CYCLES    = 3,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // Event side: an event transfers on a rising clk edge where event_valid && event_ready;
   // event_ready is high exactly while the FSM is IDLE and does not depend on event_valid.
   input  logic                       event_valid,
   input  logic [DVS_X_ADDR_BITS-1:0] event_x,
   input  logic [DVS_Y_ADDR_BITS-1:0] event_y,
   input  logic                       event_polarity,
   output logic                       event_ready,
   output logic                       busy,
   output logic [15:0]                tx_event_count,
   output logic                       tx_error,
   output logic [1:0]                 dbg_state,
   dvs_aer_transmitter_if.master      aer_if
);

   if (SETUP_CYCLES < 1) begin : g_bad_setup
      $error("SETUP_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
   if (DVS_X_ADDR_BITS > 9 || DVS_Y_ADDR_BITS > 10) begin : g_bad_width
      $error("address widths do not fit the 10-bit AER word");
   end

   typedef enum logic [1:0] {IDLE, SETUP, REQ_HIGH, REQ_LOW} state_t;

   localparam int SW = $clog2(SETUP_CYCLES + 1);
   localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES);

   state_t state, state_n;

   logic                       ack_s1, ack_synced;
   logic [DVS_X_ADDR_BITS-1:0] x_r;
   logic [DVS_Y_ADDR_BITS-1:0] y_r, last_y;
   logic                       pol_r, last_y_valid, phase_x;
   logic [SW-1:0]              setup_cnt;
   logic [9:0]                 aer_q;
   logic                       xsel_q, req_q, tx_error_q;
   logic [15:0]                count_q;

   logic accept, start_x, req_set, req_clr, word_done, timeout, to_hit, same_row;

   function automatic logic [9:0] x_word(input logic [DVS_X_ADDR_BITS-1:0] x, input logic p);
      logic [9:0] w;
      w                    = '0;
      w[DVS_X_ADDR_BITS:1] = x;
      w[0]                 = p;
      return w;
   endfunction

   function automatic logic [9:0] y_word(input logic [DVS_Y_ADDR_BITS-1:0] y);
      logic [9:0] w;
      w                      = '0;
      w[DVS_Y_ADDR_BITS-1:0] = y;
      return w;
   endfunction

   // ack arrives from another clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_s1     <= 1'b0;
         ack_synced <= 1'b0;
      end else begin
         ack_s1     <= aer_if.ack;
         ack_synced <= ack_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   assign same_row = last_y_valid && (event_y == last_y);

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      start_x   = 1'b0;
      req_set   = 1'b0;
      req_clr   = 1'b0;
      word_done = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (event_valid) begin
               accept  = 1'b1;
               state_n = SETUP;
            end
         end
         SETUP: begin
            // req may only rise once the previous ack has been seen low
            if (setup_cnt == SETUP_LAST && !ack_synced) begin
               req_set = 1'b1;
               state_n = REQ_HIGH;
            end
         end
         REQ_HIGH: begin
            if (ack_synced) begin
               req_clr = 1'b1;
               state_n = REQ_LOW;
            end
         end
         REQ_LOW: begin
            if (!ack_synced) begin
               if (!phase_x) begin
                  start_x = 1'b1;
                  state_n = SETUP;
               end else begin
                  word_done = 1'b1;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (to_hit) begin
         timeout   = 1'b1;
         start_x   = 1'b0;
         word_done = 1'b0;
         req_clr   = 1'b1;
         state_n   = IDLE;
      end
   end

`ifdef DVS_AER_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    to_cnt <= '0;
      else if (state_n != state)                     to_cnt <= '0;
      else if (state == REQ_HIGH || state == REQ_LOW) to_cnt <= to_cnt + TW'(1);
   end

   assign to_hit = (state == REQ_HIGH || state == REQ_LOW) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r          <= '0;
         y_r          <= '0;
         pol_r        <= 1'b0;
         last_y       <= '0;
         last_y_valid <= 1'b0;
         phase_x      <= 1'b0;
         setup_cnt    <= '0;
         aer_q        <= '0;
         xsel_q       <= 1'b0;
         req_q        <= 1'b0;
         tx_error_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         tx_error_q <= timeout;
         if (accept) begin
            x_r   <= event_x;
            y_r   <= event_y;
            pol_r <= event_polarity;
            // a Y word is only needed when the row differs from the last one sent
            if (same_row) begin
               aer_q   <= x_word(event_x, event_polarity);
               xsel_q  <= 1'b1;
               phase_x <= 1'b1;
            end else begin
               aer_q   <= y_word(event_y);
               xsel_q  <= 1'b0;
               phase_x <= 1'b0;
            end
         end
         if (start_x) begin
            aer_q        <= x_word(x_r, pol_r);
            xsel_q       <= 1'b1;
            phase_x      <= 1'b1;
            last_y       <= y_r;
            last_y_valid <= 1'b1;
         end
         if (accept || start_x)                            setup_cnt <= '0;
         else if (state == SETUP && setup_cnt != SETUP_LAST) setup_cnt <= setup_cnt + SW'(1);
         if (req_set) req_q <= 1'b1;
         if (req_clr) req_q <= 1'b0;
         if (word_done) count_q <= count_q + 16'd1;
         if (timeout) begin
            aer_q        <= '0;
            xsel_q       <= 1'b0;
            last_y_valid <= 1'b0;
         end
      end
   end

   assign event_ready    = (state == IDLE);
   assign busy           = (state != IDLE);
   assign dbg_state      = state;
   assign tx_event_count = count_q;
   assign tx_error       = tx_error_q;
   assign aer_if.aer     = aer_q;
   assign aer_if.xsel    = xsel_q;
   assign aer_if.req     = req_q;

endmodule

// File: doc/dvs_aer_transmitter.md
# dvs_aer_transmitter

Transmit-side model of the DVS camera's word-serial AER bus: takes parallel events (x, y, polarity) over a valid/ready interface and emits them as Y-address and X-address words on `aer`/`xsel`/`req` with a four-phase handshake against an asynchronous `ack`. It drives `dvs_aer_receiver` in loopback and FPGA emulation builds, replacing the physical camera. A Y word is only sent when the row changes, matching camera behaviour.

## Interface
- `SETUP_CYCLES`, default 3: cycles `aer`/`xsel` are stable before `req` rises (minimum 1).
- `TIMEOUT_CYCLES`, default 1024: handshake watchdog limit. Used only with `DVS_AER_TX_TIMEOUT_EN`.
- `clk`  in  1  system clock (`CLK_PERIOD_NS` from `dvs_ravens_pkg`).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `event_valid`  in  1  event offered.
- `event_x`  in  `DVS_X_ADDR_BITS`  column address.
- `event_y`  in  `DVS_Y_ADDR_BITS`  row address.
- `event_polarity`  in  1  ON=1 / OFF=0.
- `event_ready`  out  1  event accepted when `event_valid && event_ready`.
- `aer`  out  10  AER word.
- `xsel`  out  1  0 = Y word, 1 = X word.
- `req`  out  1  request to receiver.
- `ack`  in  1  asynchronous acknowledge, double-FF synchronised internally.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `tx_event_count`  out  16  completed X words, wraps at 0xFFFF→0.
- `tx_error`  out  1  one-cycle pulse on handshake timeout.

## Operation
- States: IDLE, SETUP, REQ_HIGH, REQ_LOW.
- IDLE: `event_ready`=1 (combinational, `state==IDLE`). On accept, register x/y/polarity.
  - If `last_y_valid && event_y==last_y`, phase=X. Otherwise phase=Y.
  - Go to SETUP.
- SETUP: `aer`/`xsel` are registered and driven from the cycle after entry.
  - Y word: `aer[DVS_Y_ADDR_BITS-1:0]`=y, upper bits 0, `xsel`=0.
  - X word: `aer[DVS_X_ADDR_BITS:1]`=x, `aer[0]`=polarity, remaining bits 0, `xsel`=1.
  - After `SETUP_CYCLES` cycles, assert `req` and go to REQ_HIGH.
- REQ_HIGH: wait for `ack_synced`=1, then deassert `req` and go to REQ_LOW.
- REQ_LOW: `aer`/`xsel` stay held. Wait for `ack_synced`=0.
  - If phase=Y: set `last_y`=y, `last_y_valid`=1, phase=X, go to SETUP.
  - If phase=X: increment `tx_event_count`, go to IDLE.
- `req` is registered and glitch-free. It never rises while `ack_synced`=1: if `ack_synced` is still 1 on exit from SETUP, hold in SETUP.
- Reset values: `req`=0, `aer`=0, `xsel`=0, `tx_event_count`=0, `tx_error`=0, `busy`=0, `event_ready`=1 (state=IDLE), `last_y_valid`=0, sync FFs=0.
- Reset mid-handshake: `req` drops immediately (asynchronous) and the FSM returns to IDLE. The first event after reset always sends a Y word.

## Timing
- Accept at edge N: `aer`/`xsel` valid at N+1. `req` rises at N+1+`SETUP_CYCLES`.
- `ack` to `req` fall: 2 sync cycles plus 1 registered cycle = 3 cycles after the `ack` edge is sampled. Same latency for `ack` fall to next word setup.
- Row-change event latency: two full handshakes. Same-row event: one handshake.
- Back-to-back: after X-word completion, IDLE holds for 1 cycle minimum, then the next accept.
- `tx_event_count` updates on the edge leaving REQ_LOW for IDLE.
- Against `dvs_aer_receiver` with 0-cycle ack latency, one X word takes ≈`SETUP_CYCLES`+8 cycles.

## Configuration
- `DVS_AER_TX_TIMEOUT_EN` defined:
  - A counter runs in REQ_HIGH and REQ_LOW and resets on each state entry.
  - When it reaches `TIMEOUT_CYCLES`: drop `req`, set `aer`=0 and `xsel`=0, clear `last_y_valid`, pulse `tx_error` for 1 cycle, go to IDLE.
  - `tx_event_count` is not incremented.
- Undefined:
  - No counter; the handshake waits indefinitely.
  - `tx_error` is tied 0 and `TIMEOUT_CYCLES` is ignored.

## Test plan
- After reset, offer x=17, y=42, pol=1 with a responsive ack model -> Y word `aer`=0x02A/`xsel`=0, then X word `aer`=0x023/`xsel`=1; `tx_event_count`=1.
- Offer (x=5,y=42,pol=0) then (x=6,y=42,pol=1) -> second event sends only X word 0x00D; `tx_event_count`=2.
- Offer (x=5,y=42) then (x=5,y=43) -> Y word 0x02B is re-sent before X word 0x00A.
- Hold `ack`=1 from before `req` rises -> `req` stays 0 in SETUP until `ack` drops, then rises 3+ cycles later.
- Assert `rst_n`=0 while `req`=1 -> `req`=0 immediately, `busy`=0; next event sends a Y word first.
- With `DVS_AER_TX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16 and `ack` stuck at 0 -> `req` falls 16 cycles after rising, `tx_error` pulses once, `tx_event_count` unchanged.
